seq_detect_param: RTL and testbench
===================================

Name: seq_detect_param

Overview:
Parameterised, runtime-programmable serial bit-pattern detector. It is the generalised successor to the fixed 4-bit Moore detectors in the FSM library. Pattern and length (1..MAX_LEN) are loadable at run time. Overlapping or non-overlapping matching is selectable, input is qualified by a valid strobe, and a saturating match counter is included. It sits after serial front-ends (UART RX bit stream, line decoders) to flag sync words and frame markers.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (2..32)
CNT_W, 8, match counter width
DEFAULT_PAT, 8'b0000_1011, pattern loaded at reset (MAX_LEN bits, LSB = last bit received)
DEFAULT_LEN, 4, pattern length loaded at reset
LEN_W (localparam), $clog2(MAX_LEN+1), width of length fields

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high; clock clk
in_valid  input  1  in_bit is sampled on this cycle
in_bit  input  1  serial data bit
pat_load  input  1  load pat_in/len_in this cycle
pat_in  input  MAX_LEN  new pattern, LSB = last bit of sequence
len_in  input  LEN_W  new pattern length
overlap_en  input  1  1 = overlapping matches allowed, 0 = restart after match
count_clr  input  1  synchronous clear of match_count
detect  output  1  registered one-cycle match pulse
match_count  output  CNT_W  saturating number of matches
busy_fill  output  LEN_W  number of valid history bits currently held (0..MAX_LEN)

Behaviour:
- Reset: pattern_r=DEFAULT_PAT, len_r=DEFAULT_LEN, hist=0, fill=0, detect=0, match_count=0, busy_fill=0.
- State: hist (MAX_LEN-bit shift register, newest bit at LSB), fill counter, pattern_r, len_r. Moore style: detect is a register and never depends combinationally on inputs.
- Sampling: on a clk edge with in_valid=1 and pat_load=0:
  - hist <= {hist[MAX_LEN-2:0], in_bit}.
  - fill_nxt = min(fill+1, MAX_LEN).
- Match: match = (fill_nxt >= len_r) && ((hist_nxt ^ pattern_r) & mask) == 0, where mask = low len_r bits set.
- Detect timing: detect <= match on the same edge. detect is high for exactly the cycle after the edge that sampled the completing bit. Latency is 1 clock.
- Idle cycles: when in_valid=0, hist and fill hold and detect <= 0. Consecutive detects only occur on back-to-back valid matches.
- Overlap: overlap_en=1 keeps fill = fill_nxt after a match. overlap_en=0 sets fill <= 0 on a match, so the next match needs len_r fresh bits; stale history bits are masked by fill. overlap_en may change on any cycle and takes effect on the next sample.
- Pattern load: pat_load=1 sets pattern_r <= pat_in and len_r <= clamp(len_in). Clamp rule: 0 becomes 1, and values above MAX_LEN become MAX_LEN. The same edge sets fill <= 0 and detect <= 0. in_valid is ignored on a load cycle (pat_load has priority). match_count is unaffected.
- Counter: match_count += 1 on each match, saturating at 2^CNT_W-1 (no wrap).
- Counter clear: count_clr=1 clears match_count. If a clear and a match occur on the same edge, the clear wins and the result is 0.
- busy_fill: equals fill (registered).
- Asynchronous reset mid-stream: aborts any partial match immediately. detect drops without waiting for a clock edge, and the pattern reverts to DEFAULT_PAT/DEFAULT_LEN.
- Width rules:
  - All comparisons are unsigned.
  - fill saturates at MAX_LEN.
  - len_r is never 0 after any load.

Test Plan:
1. Defaults (1011, len 4), overlap_en=1: bits 1,0,1,1 with in_valid every cycle. Expect detect=1 only in the cycle after the 4th bit, match_count=1, busy_fill=4.
2. Overlap comparison on stream 1,0,1,1,0,1,1:
   - overlap_en=1: detect after bits 4 and 7, count=2.
   - Repeat after reset with overlap_en=0: detect after bit 4 only, count=1, busy_fill=3 at end.
3. Gapped input: the 1011 bits are separated by 2 idle cycles each. Expect a single detect pulse after the 4th valid bit, detect=0 on all idle cycles, count=1.
4. Pattern load pat_in=8'hE7, len_in=8, then stream 1,1,1,0,0,1,1,1. Expect detect after the 8th bit only; the earlier 1011-like substrings do not match. Loading len_in=0 gives len_r=1 (every matching single bit pulses). len_in=9 gives len_r=8.
5. Counter with CNT_W=2: 5 back-to-back overlapped matches of pattern 1 (len 1) saturate match_count at 3. count_clr asserted together with a match gives 0 next cycle.
6. Reset mid-operation: send 1,0,1, pulse reset, then send 1. Expect no detect, match_count=0, busy_fill=1, pattern back to 1011.

Source files
------------

// File: rtl/seq_detect_param.sv
// Runtime-programmable serial pattern detector with a valid-qualified input,
// selectable overlapping matching and a saturating match counter.
// Received bits are shifted into hist with the newest bit at the LSB. A match
// compares the low len_r bits of hist against pattern_r. The fill counter
// masks history that is stale after a load, after a reset, or after a
// non-overlapping match.
module seq_detect_param #(
  parameter int unsigned         MAX_LEN     = 8,
  parameter int unsigned         CNT_W       = 8,
  parameter logic [MAX_LEN-1:0]  DEFAULT_PAT = 8'b0000_1011,
  parameter int unsigned         DEFAULT_LEN = 4,
  localparam int unsigned        LEN_W       = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic               in_bit,
  input  logic               pat_load,
  input  logic [MAX_LEN-1:0] pat_in,
  input  logic [LEN_W-1:0]   len_in,
  input  logic               overlap_en,
  input  logic               count_clr,
  output logic               detect,
  output logic [CNT_W-1:0]   match_count,
  output logic [LEN_W-1:0]   busy_fill
);

  logic [MAX_LEN-1:0] hist;
  logic [MAX_LEN-1:0] pattern_r;
  logic [LEN_W-1:0]   fill;
  logic [LEN_W-1:0]   len_r;

  logic [MAX_LEN-1:0] hist_nxt;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   fill_nxt;
  logic [LEN_W-1:0]   len_clamped;
  logic               match;

  // Next history and fill, compare mask, match decision and load-length clamp
  always_comb begin
    hist_nxt = {hist[MAX_LEN-2:0], in_bit};
    fill_nxt = (fill == LEN_W'(MAX_LEN)) ? fill : fill + LEN_W'(1);
    // len_r never exceeds MAX_LEN, so a shift by MAX_LEN yields an all-ones mask
    mask     = ~({MAX_LEN{1'b1}} << len_r);
    match    = in_valid && !pat_load && (fill_nxt >= len_r) &&
               (((hist_nxt ^ pattern_r) & mask) == '0);
    if (len_in == '0) begin
      len_clamped = LEN_W'(1);
    end else if (len_in > LEN_W'(MAX_LEN)) begin
      len_clamped = LEN_W'(MAX_LEN);
    end else begin
      len_clamped = len_in;
    end
  end

  // Pattern registers, shift history, fill tracking and registered detect pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pattern_r <= DEFAULT_PAT;
      len_r     <= LEN_W'(DEFAULT_LEN);
      hist      <= '0;
      fill      <= '0;
      detect    <= 1'b0;
    end else if (pat_load) begin
      pattern_r <= pat_in;
      len_r     <= len_clamped;
      fill      <= '0;
      detect    <= 1'b0;
    end else if (in_valid) begin
      hist   <= hist_nxt;
      detect <= match;
      fill   <= (match && !overlap_en) ? '0 : fill_nxt;
    end else begin
      detect <= 1'b0;
    end
  end

  // Saturating match counter; a clear overrides a coincident match
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      match_count <= '0;
    end else if (count_clr) begin
      match_count <= '0;
    end else if (match && (match_count != '1)) begin
      match_count <= match_count + CNT_W'(1);
    end
  end

  assign busy_fill = fill;

endmodule

// File: tb/tb_seq_detect_param.sv
// Self-checking bench for seq_detect_param. Each scenario builds a list of
// steps. A step holds the inputs for one clock and the hand-derived outputs
// expected after that edge. The expected part is queued when the step is
// driven and popped for comparison once the edge has happened.
// A second instance with CNT_W=2 exercises counter saturation.
module tb_seq_detect_param;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_bit;
  logic       pat_load;
  logic [7:0] pat_in;
  logic [3:0] len_in;
  logic       overlap_en;
  logic       count_clr;

  logic       detect;
  logic [7:0] match_count;
  logic [3:0] busy_fill;
  logic       detect2;
  logic [1:0] match_count2;
  logic [3:0] busy_fill2;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic       v, b, ld, clr, ov, arst, det;
    logic [7:0] pat, cnt;
    logic [3:0] len, fill;
  } step_t;

  step_t sb[$];

  seq_detect_param #(.MAX_LEN(8), .CNT_W(8)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
    .pat_load(pat_load), .pat_in(pat_in), .len_in(len_in),
    .overlap_en(overlap_en), .count_clr(count_clr),
    .detect(detect), .match_count(match_count), .busy_fill(busy_fill)
  );

  seq_detect_param #(.MAX_LEN(8), .CNT_W(2)) u_dut_c2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
    .pat_load(pat_load), .pat_in(pat_in), .len_in(len_in),
    .overlap_en(overlap_en), .count_clr(count_clr),
    .detect(detect2), .match_count(match_count2), .busy_fill(busy_fill2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic step_t mk(input logic v, b, ld, input logic [7:0] pat,
                               input logic [3:0] len, input logic clr, ov, arst, det,
                               input int c, f);
    step_t s;
    s.v = v; s.b = b; s.ld = ld; s.pat = pat; s.len = len; s.clr = clr;
    s.ov = ov; s.arst = arst; s.det = det; s.cnt = 8'(c); s.fill = 4'(f);
    return s;
  endfunction

  // valid data bit
  function automatic step_t vb(input logic b, ov, det, input int c, f);
    return mk(1'b1, b, 1'b0, 8'h00, 4'd0, 1'b0, ov, 1'b0, det, c, f);
  endfunction

  // idle cycle
  function automatic step_t idle(input int c, f);
    return mk(1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, c, f);
  endfunction

  task automatic do_reset(input logic ov);
    reset = 1'b1; in_valid = 1'b0; in_bit = 1'b0; pat_load = 1'b0;
    pat_in = 8'h00; len_in = 4'd0; count_clr = 1'b0; overlap_en = ov;
    @(posedge clk); #3;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_bit = 1'b0; pat_load = 1'b0;
    pat_in = 8'h00; len_in = 4'd0; count_clr = 1'b0; overlap_en = 1'b1;
    #2;
    n_cmp++; if (detect !== 1'b0) begin n_bad++; $display("FAIL reset_detect got %b want 0", detect); end
    n_cmp++; if (match_count !== 8'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", match_count); end
    n_cmp++; if (busy_fill !== 4'd0) begin n_bad++; $display("FAIL reset_fill got %0d want 0", busy_fill); end
    n_cmp++; if (detect2 !== 1'b0) begin n_bad++; $display("FAIL reset_detect2 got %b want 0", detect2); end
    n_cmp++; if (match_count2 !== 2'd0) begin n_bad++; $display("FAIL reset_count2 got %0d want 0", match_count2); end
    @(posedge clk); #3;
    reset = 1'b0;
  endtask

  task automatic test_default();
    step_t s[$];
    step_t e;
    do_reset(1'b1);
    s.push_back(vb(1, 1, 0, 0, 1));
    s.push_back(vb(0, 1, 0, 0, 2));
    s.push_back(vb(1, 1, 0, 0, 3));
    s.push_back(vb(1, 1, 1, 1, 4));
    s.push_back(idle(1, 4));
    foreach (s[i]) begin
      if (s[i].arst) begin reset = 1'b1; #2; reset = 1'b0; #1; end
      in_valid = s[i].v; in_bit = s[i].b; pat_load = s[i].ld; pat_in = s[i].pat;
      len_in = s[i].len; count_clr = s[i].clr; overlap_en = s[i].ov;
      sb.push_back(s[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_cmp++; if (detect !== e.det) begin n_bad++; $display("FAIL default step %0d detect got %b want %b", i, detect, e.det); end
      n_cmp++; if (match_count !== e.cnt) begin n_bad++; $display("FAIL default step %0d count got %0d want %0d", i, match_count, e.cnt); end
      n_cmp++; if (busy_fill !== e.fill) begin n_bad++; $display("FAIL default step %0d fill got %0d want %0d", i, busy_fill, e.fill); end
    end
  endtask

  task automatic test_overlap();
    step_t s[$];
    step_t e;
    step_t r;
    do_reset(1'b1);
    // stream 1,0,1,1,0,1,1 with overlapping allowed
    s.push_back(vb(1, 1, 0, 0, 1));
    s.push_back(vb(0, 1, 0, 0, 2));
    s.push_back(vb(1, 1, 0, 0, 3));
    s.push_back(vb(1, 1, 1, 1, 4));
    s.push_back(vb(0, 1, 0, 1, 5));
    s.push_back(vb(1, 1, 0, 1, 6));
    s.push_back(vb(1, 1, 1, 2, 7));
    // same stream after an async reset with overlap disabled
    r = vb(1, 0, 0, 0, 1);
    r.arst = 1'b1;
    s.push_back(r);
    s.push_back(vb(0, 0, 0, 0, 2));
    s.push_back(vb(1, 0, 0, 0, 3));
    s.push_back(vb(1, 0, 1, 1, 0));
    s.push_back(vb(0, 0, 0, 1, 1));
    s.push_back(vb(1, 0, 0, 1, 2));
    s.push_back(vb(1, 0, 0, 1, 3));
    foreach (s[i]) begin
      if (s[i].arst) begin reset = 1'b1; #2; reset = 1'b0; #1; end
      in_valid = s[i].v; in_bit = s[i].b; pat_load = s[i].ld; pat_in = s[i].pat;
      len_in = s[i].len; count_clr = s[i].clr; overlap_en = s[i].ov;
      sb.push_back(s[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_cmp++; if (detect !== e.det) begin n_bad++; $display("FAIL overlap step %0d detect got %b want %b", i, detect, e.det); end
      n_cmp++; if (match_count !== e.cnt) begin n_bad++; $display("FAIL overlap step %0d count got %0d want %0d", i, match_count, e.cnt); end
      n_cmp++; if (busy_fill !== e.fill) begin n_bad++; $display("FAIL overlap step %0d fill got %0d want %0d", i, busy_fill, e.fill); end
    end
  endtask

  task automatic test_gapped();
    step_t s[$];
    step_t e;
    do_reset(1'b1);
    s.push_back(vb(1, 1, 0, 0, 1)); s.push_back(idle(0, 1)); s.push_back(idle(0, 1));
    s.push_back(vb(0, 1, 0, 0, 2)); s.push_back(idle(0, 2)); s.push_back(idle(0, 2));
    s.push_back(vb(1, 1, 0, 0, 3)); s.push_back(idle(0, 3)); s.push_back(idle(0, 3));
    s.push_back(vb(1, 1, 1, 1, 4)); s.push_back(idle(1, 4)); s.push_back(idle(1, 4));
    foreach (s[i]) begin
      if (s[i].arst) begin reset = 1'b1; #2; reset = 1'b0; #1; end
      in_valid = s[i].v; in_bit = s[i].b; pat_load = s[i].ld; pat_in = s[i].pat;
      len_in = s[i].len; count_clr = s[i].clr; overlap_en = s[i].ov;
      sb.push_back(s[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_cmp++; if (detect !== e.det) begin n_bad++; $display("FAIL gapped step %0d detect got %b want %b", i, detect, e.det); end
      n_cmp++; if (match_count !== e.cnt) begin n_bad++; $display("FAIL gapped step %0d count got %0d want %0d", i, match_count, e.cnt); end
      n_cmp++; if (busy_fill !== e.fill) begin n_bad++; $display("FAIL gapped step %0d fill got %0d want %0d", i, busy_fill, e.fill); end
    end
  endtask

  task automatic test_pattern_load();
    step_t s[$];
    step_t e;
    logic [7:0] seq8;
    do_reset(1'b1);
    seq8 = 8'hE7;
    // load 0xE7/8 with in_valid high: the bit on the load cycle is ignored
    s.push_back(mk(1, 1, 1, 8'hE7, 4'd8, 0, 1, 0, 0, 0, 0));
    for (int k = 0; k < 8; k++) s.push_back(vb(seq8[7-k], 1, (k == 7), (k == 7) ? 1 : 0, k + 1));
    // len_in=0 clamps to 1: single-bit pattern "1"
    s.push_back(mk(0, 0, 1, 8'h01, 4'd0, 0, 1, 0, 0, 1, 0));
    s.push_back(vb(1, 1, 1, 2, 1));
    s.push_back(vb(0, 1, 0, 2, 2));
    s.push_back(vb(1, 1, 1, 3, 3));
    // len_in=9 clamps to 8
    s.push_back(mk(0, 0, 1, 8'hE7, 4'd9, 0, 1, 0, 0, 3, 0));
    for (int k = 0; k < 8; k++) s.push_back(vb(seq8[7-k], 1, (k == 7), (k == 7) ? 4 : 3, k + 1));
    foreach (s[i]) begin
      if (s[i].arst) begin reset = 1'b1; #2; reset = 1'b0; #1; end
      in_valid = s[i].v; in_bit = s[i].b; pat_load = s[i].ld; pat_in = s[i].pat;
      len_in = s[i].len; count_clr = s[i].clr; overlap_en = s[i].ov;
      sb.push_back(s[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_cmp++; if (detect !== e.det) begin n_bad++; $display("FAIL load step %0d detect got %b want %b", i, detect, e.det); end
      n_cmp++; if (match_count !== e.cnt) begin n_bad++; $display("FAIL load step %0d count got %0d want %0d", i, match_count, e.cnt); end
      n_cmp++; if (busy_fill !== e.fill) begin n_bad++; $display("FAIL load step %0d fill got %0d want %0d", i, busy_fill, e.fill); end
    end
  endtask

  task automatic test_counter_sat();
    step_t s[$];
    step_t e;
    do_reset(1'b1);
    s.push_back(mk(0, 0, 1, 8'h01, 4'd1, 0, 1, 0, 0, 0, 0));
    s.push_back(vb(1, 1, 1, 1, 1));
    s.push_back(vb(1, 1, 1, 2, 2));
    s.push_back(vb(1, 1, 1, 3, 3));
    s.push_back(vb(1, 1, 1, 3, 4));
    s.push_back(vb(1, 1, 1, 3, 5));
    // clear coincident with a match wins
    s.push_back(mk(1, 1, 0, 8'h00, 4'd0, 1, 1, 0, 1, 0, 6));
    s.push_back(vb(1, 1, 1, 1, 7));
    s.push_back(idle(1, 7));
    foreach (s[i]) begin
      if (s[i].arst) begin reset = 1'b1; #2; reset = 1'b0; #1; end
      in_valid = s[i].v; in_bit = s[i].b; pat_load = s[i].ld; pat_in = s[i].pat;
      len_in = s[i].len; count_clr = s[i].clr; overlap_en = s[i].ov;
      sb.push_back(s[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_cmp++; if (detect2 !== e.det) begin n_bad++; $display("FAIL counter step %0d detect got %b want %b", i, detect2, e.det); end
      n_cmp++; if (match_count2 !== e.cnt[1:0]) begin n_bad++; $display("FAIL counter step %0d count got %0d want %0d", i, match_count2, e.cnt[1:0]); end
      n_cmp++; if (busy_fill2 !== e.fill) begin n_bad++; $display("FAIL counter step %0d fill got %0d want %0d", i, busy_fill2, e.fill); end
    end
  endtask

  task automatic test_reset_mid();
    step_t s[$];
    step_t e;
    step_t r;
    do_reset(1'b1);
    // pattern "000" so that a pattern that fails to revert stays silent below
    s.push_back(mk(0, 0, 1, 8'h00, 4'd3, 0, 1, 0, 0, 0, 0));
    s.push_back(vb(1, 1, 0, 0, 1));
    s.push_back(vb(0, 1, 0, 0, 2));
    s.push_back(vb(1, 1, 0, 0, 3));
    r = vb(1, 1, 0, 0, 1);
    r.arst = 1'b1;
    s.push_back(r);
    s.push_back(vb(0, 1, 0, 0, 2));
    s.push_back(vb(1, 1, 0, 0, 3));
    s.push_back(vb(1, 1, 1, 1, 4));
    foreach (s[i]) begin
      if (s[i].arst) begin reset = 1'b1; #2; reset = 1'b0; #1; end
      in_valid = s[i].v; in_bit = s[i].b; pat_load = s[i].ld; pat_in = s[i].pat;
      len_in = s[i].len; count_clr = s[i].clr; overlap_en = s[i].ov;
      sb.push_back(s[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_cmp++; if (detect !== e.det) begin n_bad++; $display("FAIL rstmid step %0d detect got %b want %b", i, detect, e.det); end
      n_cmp++; if (match_count !== e.cnt) begin n_bad++; $display("FAIL rstmid step %0d count got %0d want %0d", i, match_count, e.cnt); end
      n_cmp++; if (busy_fill !== e.fill) begin n_bad++; $display("FAIL rstmid step %0d fill got %0d want %0d", i, busy_fill, e.fill); end
    end
    // detect is high here; an async reset must drop it before any clock edge
    in_valid = 1'b0;
    #2; reset = 1'b1; #1;
    n_cmp++; if (detect !== 1'b0) begin n_bad++; $display("FAIL async_detect got %b want 0", detect); end
    n_cmp++; if (match_count !== 8'd0) begin n_bad++; $display("FAIL async_count got %0d want 0", match_count); end
    n_cmp++; if (busy_fill !== 4'd0) begin n_bad++; $display("FAIL async_fill got %0d want 0", busy_fill); end
    #2; reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_default();
    test_overlap();
    test_gapped();
    test_pattern_load();
    test_counter_sat();
    test_reset_mid();
    if (sb.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard_drain got %0d leftover want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
